// File: rtl/axi_line_burst_ctrl.sv
// rtl/axi_line_burst_ctrl.sv - AXI4 burst master moving one cache line between the line buffer and memory
module axi_line_burst_ctrl #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        i_start_read,
  input  logic                        i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_buf_shift,
  output logic                        o_buf_read,
  output logic                        o_buf_write,
  output logic [AXI_DATA_WIDTH-1:0]   o_buf_data,
  input  logic [AXI_DATA_WIDTH-1:0]   i_buf_data,
  output logic [AXI_ADDR_WIDTH-1:0]   o_araddr,
  output logic [7:0]                  o_arlen,
  output logic [2:0]                  o_arsize,
  output logic [1:0]                  o_arburst,
  output logic                        o_arvalid,
  input  logic                        i_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]                  i_rresp,
  input  logic                        i_rlast,
  input  logic                        i_rvalid,
  output logic                        o_rready,
  output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
  output logic [7:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                        o_wlast,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  input  logic [1:0]                  i_bresp,
  input  logic                        i_bvalid,
  output logic                        o_bready
);

  localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [7:0]                BURST_LEN = 8'(BEATS - 1);
  localparam logic [2:0]                BEAT_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = {AXI_ADDR_WIDTH{1'b1}} << OFF_W;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic                      err_q;
  logic                      buf_read_q;
  logic                      buf_write_q;
  logic                      r_hs;
  logic                      w_hs;
  logic                      last_beat;

  assign r_hs      = (state == S_R) && i_rvalid;
  assign w_hs      = (state == S_W) && i_wready;
  assign last_beat = (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (arst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt         <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      buf_read_q  <= 1'b0;
      buf_write_q <= 1'b0;
    end else begin
      if (state == S_DONE) begin
        cnt <= '0;
      end else if ((r_hs || w_hs) && !last_beat) begin
        cnt <= cnt + 1'b1;
      end

      if (state == S_IDLE && state_nxt != S_IDLE) begin
        addr_q <= i_addr & ADDR_MASK;
        err_q  <= 1'b0;
      end else if (r_hs && ((i_rresp != 2'b00) || (i_rlast != last_beat))) begin
        err_q <= 1'b1;
      end else if ((state == S_B) && i_bvalid && (i_bresp != 2'b00)) begin
        err_q <= 1'b1;
      end

      // Holds cover DONE only for the transaction that just finished.
      buf_read_q  <= (state_nxt == S_AR) || (state_nxt == S_R) ||
                     ((state_nxt == S_DONE) && (state == S_R));
      buf_write_q <= (state_nxt == S_AW) || (state_nxt == S_W) || (state_nxt == S_B) ||
                     ((state_nxt == S_DONE) && (state == S_B));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start_write) begin
          state_nxt = S_AW;
        end else if (i_start_read) begin
          state_nxt = S_AR;
        end
      end
      S_AR:   if (i_arready) state_nxt = S_R;
      S_R:    if (r_hs && last_beat) state_nxt = S_DONE;
      S_AW:   if (i_awready) state_nxt = S_W;
      S_W:    if (w_hs && last_beat) state_nxt = S_B;
      S_B:    if (i_bvalid) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_wlast     = 1'b0;
    o_bready    = 1'b0;
    o_buf_shift = 1'b0;
    o_done      = 1'b0;
    o_error     = 1'b0;
    case (state)
      S_AR: o_arvalid = 1'b1;
      S_R: begin
        o_rready    = 1'b1;
        o_buf_shift = i_rvalid;
      end
      S_AW: o_awvalid = 1'b1;
      S_W: begin
        o_wvalid    = 1'b1;
        o_wlast     = last_beat;
        o_buf_shift = i_wready;
      end
      S_B: o_bready = 1'b1;
      S_DONE: begin
        o_done  = 1'b1;
        o_error = err_q;
      end
      default: ;
    endcase
  end

  assign o_buf_read  = buf_read_q;
  assign o_buf_write = buf_write_q;
  assign o_buf_data  = i_rdata;
  assign o_wdata     = i_buf_data;
  assign o_wstrb     = '1;

  assign o_araddr  = addr_q;
  assign o_arlen   = BURST_LEN;
  assign o_arsize  = BEAT_SIZE;
  assign o_arburst = 2'b01;
  assign o_awaddr  = addr_q;
  assign o_awlen   = BURST_LEN;
  assign o_awsize  = BEAT_SIZE;
  assign o_awburst = 2'b01;

endmodule

// File: tb/tb_axi_line_burst_ctrl.sv
// tb/tb_axi_line_burst_ctrl.sv - directed self-checking bench for axi_line_burst_ctrl
module tb_axi_line_burst_ctrl;

  logic        clk = 1'b0;
  logic        arst;
  logic        i_start_read, i_start_write;
  logic [31:0] i_addr;
  logic        o_done, o_error, o_buf_shift, o_buf_read, o_buf_write;
  logic [31:0] o_buf_data, i_buf_data;
  logic [31:0] o_araddr;
  logic [7:0]  o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;
  logic        o_arvalid, i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rlast, i_rvalid, o_rready;
  logic [31:0] o_awaddr;
  logic [7:0]  o_awlen;
  logic [2:0]  o_awsize;
  logic [1:0]  o_awburst;
  logic        o_awvalid, i_awready;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_wlast, o_wvalid, i_wready;
  logic [1:0]  i_bresp;
  logic        i_bvalid, o_bready;

  int checks = 0;
  int errors = 0;
  logic [31:0] wbuf [16];

  axi_line_burst_ctrl dut (
    .clk(clk), .arst(arst),
    .i_start_read(i_start_read), .i_start_write(i_start_write), .i_addr(i_addr),
    .o_done(o_done), .o_error(o_error),
    .o_buf_shift(o_buf_shift), .o_buf_read(o_buf_read), .o_buf_write(o_buf_write),
    .o_buf_data(o_buf_data), .i_buf_data(i_buf_data),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_arvalid"}, o_arvalid, 0);
    check({tag, "_rready"}, o_rready, 0);
    check({tag, "_awvalid"}, o_awvalid, 0);
    check({tag, "_wvalid"}, o_wvalid, 0);
    check({tag, "_wlast"}, o_wlast, 0);
    check({tag, "_bready"}, o_bready, 0);
    check({tag, "_shift"}, o_buf_shift, 0);
    check({tag, "_buf_read"}, o_buf_read, 0);
    check({tag, "_buf_write"}, o_buf_write, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_error"}, o_error, 0);
  endtask

  // Presents a request in cycle N and returns #1 into cycle N+1.
  task automatic req(input bit rd, input bit wr, input bit hold_rd, input logic [31:0] a);
    i_addr = a;
    i_start_read = rd;
    i_start_write = wr;
    #1;
    check("req_arvalid", o_arvalid, 0);
    check("req_awvalid", o_awvalid, 0);
    @(posedge clk); #1;
    i_start_write = 1'b0;
    if (!hold_rd) i_start_read = 1'b0;
    i_addr = 32'hFFFF_FFFF;
  endtask

  task automatic run_read(input bit stall, input int err_beat, input int last_at, input bit exp_err,
                          input logic [31:0] exp_addr, input logic [31:0] base);
    int cyc, beat, guard;
    bit hs;
    cyc = 1; guard = 0; hs = 0;
    while (!hs && guard < 100) begin
      i_arready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      check("arvalid", o_arvalid, 1);
      check("araddr", o_araddr, exp_addr);
      check("arlen", o_arlen, 15);
      check("arsize", o_arsize, 2);
      check("arburst", o_arburst, 1);
      check("buf_read_ar", o_buf_read, 1);
      check("awvalid_in_ar", o_awvalid, 0);
      hs = i_arready;
      @(posedge clk); #1; cyc++; guard++;
    end
    check("ar_handshake", hs, 1);
    i_arready = 1'b0;
    beat = 0;
    while (beat < 16 && guard < 400) begin
      i_rvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      i_rdata  = i_rvalid ? base + beat : 32'hDEAD_BEEF;
      i_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
      i_rlast  = i_rvalid && (beat == last_at);
      #1;
      check("rready", o_rready, 1);
      check("arvalid_in_r", o_arvalid, 0);
      check("r_shift", o_buf_shift, i_rvalid);
      check("r_done", o_done, 0);
      check("buf_read_r", o_buf_read, 1);
      if (i_rvalid) begin
        check("buf_data", o_buf_data, base + beat);
        beat++;
      end
      @(posedge clk); #1; cyc++; guard++;
    end
    check("r_beats", beat, 16);
    i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
    #1;
    check("r_done_pulse", o_done, 1);
    check("r_error", o_error, exp_err);
    check("r_buf_read_done", o_buf_read, 1);
    check("r_rready_done", o_rready, 0);
    check("r_shift_done", o_buf_shift, 0);
    if (!stall) check("r_latency", cyc, 18);
    @(posedge clk); #1;
    check("r_idle_done", o_done, 0);
    check("r_idle_buf_read", o_buf_read, 0);
  endtask

  task automatic run_write(input bit stall, input logic [1:0] bresp, input bit exp_err,
                           input logic [31:0] exp_addr, input int abort_at);
    int cyc, widx, guard;
    bit hs;
    cyc = 1; guard = 0; hs = 0;
    while (!hs && guard < 100) begin
      i_awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      check("awvalid", o_awvalid, 1);
      check("awaddr", o_awaddr, exp_addr);
      check("awlen", o_awlen, 15);
      check("awsize", o_awsize, 2);
      check("awburst", o_awburst, 1);
      check("wvalid_in_aw", o_wvalid, 0);
      check("arvalid_in_aw", o_arvalid, 0);
      check("buf_write_aw", o_buf_write, 1);
      hs = i_awready;
      @(posedge clk); #1; cyc++; guard++;
    end
    check("aw_handshake", hs, 1);
    i_awready = 1'b0;
    widx = 0;
    while (widx < 16 && guard < 400) begin
      i_buf_data = wbuf[widx];
      if (widx == abort_at) begin
        i_wready = 1'b1;
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        i_wready = 1'b0;
        #1;
        check_all_idle("abort");
        check("abort_araddr", o_araddr, 0);
        check("abort_awaddr", o_awaddr, 0);
        return;
      end
      i_wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("wvalid", o_wvalid, 1);
      check("wdata", o_wdata, wbuf[widx]);
      check("wlast", o_wlast, widx == 15);
      check("wstrb", o_wstrb, 4'hF);
      check("w_shift", o_buf_shift, i_wready);
      check("buf_write_w", o_buf_write, 1);
      if (i_wready) widx++;
      @(posedge clk); #1; cyc++; guard++;
    end
    check("w_beats", widx, 16);
    i_wready = 1'b0;
    hs = 0;
    while (!hs && guard < 500) begin
      i_bvalid = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      i_bresp  = bresp;
      #1;
      check("bready", o_bready, 1);
      check("wvalid_in_b", o_wvalid, 0);
      check("b_shift", o_buf_shift, 0);
      check("buf_write_b", o_buf_write, 1);
      hs = i_bvalid;
      @(posedge clk); #1; cyc++; guard++;
    end
    check("b_handshake", hs, 1);
    i_bvalid = 1'b0; i_bresp = 2'b00;
    #1;
    check("w_done_pulse", o_done, 1);
    check("w_error", o_error, exp_err);
    check("w_buf_write_done", o_buf_write, 1);
    check("w_bready_done", o_bready, 0);
    if (!stall) check("w_latency", cyc, 19);
    @(posedge clk); #1;
    check("w_idle_done", o_done, 0);
    check("w_idle_buf_write", o_buf_write, 0);
    check("w_idle_arvalid", o_arvalid, 0);
  endtask

  initial begin
    arst = 1'b1;
    i_start_read = 0; i_start_write = 0; i_addr = 0; i_buf_data = 0;
    i_arready = 0; i_rdata = 0; i_rresp = 0; i_rlast = 0; i_rvalid = 0;
    i_awready = 0; i_wready = 0; i_bresp = 0; i_bvalid = 0;
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hA0 + i;
    repeat (2) @(posedge clk);
    #1;
    check_all_idle("reset");
    check("reset_araddr", o_araddr, 0);
    check("reset_awaddr", o_awaddr, 0);
    arst = 1'b0;
    @(posedge clk); #1;

    req(1, 0, 0, 32'h0000_1234);
    run_read(0, -1, 15, 0, 32'h0000_1200, 32'h0);

    req(0, 1, 0, 32'h8000_007C);
    run_write(0, 2'b00, 0, 32'h8000_0040, -1);

    req(1, 0, 0, 32'h0000_2040);
    run_read(1, -1, 15, 0, 32'h0000_2040, 32'h100);

    req(0, 1, 0, 32'h0000_3010);
    run_write(1, 2'b10, 1, 32'h0000_3000, -1);

    req(1, 1, 1, 32'h0000_4444);
    run_write(0, 2'b00, 0, 32'h0000_4440, -1);
    i_addr = 32'h0000_5678;
    @(posedge clk); #1;
    i_start_read = 1'b0;
    i_addr = 32'hFFFF_FFFF;
    run_read(0, 5, 15, 1, 32'h0000_5640, 32'h200);

    req(1, 0, 0, 32'h0000_6000);
    run_read(0, -1, 10, 1, 32'h0000_6000, 32'h300);

    req(0, 1, 0, 32'h0000_7000);
    run_write(0, 2'b00, 0, 32'h0000_7000, 7);

    req(1, 0, 0, 32'h0000_9ABC);
    run_read(0, -1, 15, 0, 32'h0000_9A80, 32'h400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_line_burst_ctrl.md
# axi_line_burst_ctrl

AXI4 burst master that moves one cache line between the cache's line shift buffer and external memory. A refill issues an INCR read burst and shifts each returned beat into the line buffer. A write-back issues an INCR write burst and drains the buffer one beat per accepted W transfer. It sits between the cache controller FSM and the AXI4 interconnect, and it drives the line buffer's shift enable and mode signals.

## Interface

- AXI_DATA_WIDTH, 32: beat width in bits.
- AXI_ADDR_WIDTH, 32: address width.
- BLOCK_WIDTH, 512: cache line width. BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH (16). It must be a power of two.

Ports:

- clk  in  1  clock.
- arst  in  1  reset: synchronous, active-high.
- i_start_read  in  1  refill request. Sampled in IDLE only.
- i_start_write  in  1  write-back request. Sampled in IDLE only.
- i_addr  in  AXI_ADDR_WIDTH  line address. Latched at request, with the low log2(BLOCK_WIDTH/8) bits forced to 0.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  error flag for the completed transaction. Valid while o_done is high.
- o_buf_shift  out  1  line buffer shift enable.
- o_buf_read  out  1  line buffer refill-mode hold.
- o_buf_write  out  1  line buffer write-back-mode hold.
- o_buf_data  out  AXI_DATA_WIDTH  beat into the line buffer. Equals rdata.
- i_buf_data  in  AXI_DATA_WIDTH  low beat of the line buffer.
- AR channel: o_araddr, o_arlen[7:0], o_arsize[2:0], o_arburst[1:0], o_arvalid (out); i_arready (in).
- R channel: i_rdata, i_rresp[1:0], i_rlast, i_rvalid (in); o_rready (out).
- AW channel: o_awaddr, o_awlen[7:0], o_awsize[2:0], o_awburst[1:0], o_awvalid (out); i_awready (in).
- W channel: o_wdata, o_wstrb, o_wlast, o_wvalid (out); i_wready (in).
- B channel: i_bresp[1:0], i_bvalid (in); o_bready (out).

## Operation

- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE transitions:
  - i_start_write → AW. Write has priority when both requests are high, so a dirty eviction goes before its refill.
  - else i_start_read → AR.
- AR: o_arvalid=1. On i_arready → R.
- R:
  - o_rready=1.
  - Each beat (i_rvalid&o_rready): o_buf_shift=1, beat counter +1.
  - After beat BEATS-1 is accepted → DONE.
- AW: o_awvalid=1. On i_awready → W. W is never issued before AW is accepted.
- W:
  - o_wvalid=1, o_wdata=i_buf_data, o_wstrb all ones.
  - o_wlast=1 when the counter equals BEATS-1.
  - Each handshake: o_buf_shift=1, counter +1.
  - After the last beat → B.
- B: o_bready=1. On i_bvalid → DONE.
- DONE: o_done=1 for one cycle → IDLE. The counter clears.
- Fixed burst attributes:
  - arlen = awlen = BEATS-1.
  - arsize = awsize = log2(AXI_DATA_WIDTH/8).
  - arburst = awburst = 2'b01 (INCR).
- o_buf_read is high in AR, R and DONE of a refill. o_buf_write is high in AW, W, B and DONE of a write-back. Both are registered and both are low in IDLE.
- o_buf_shift, o_buf_data and o_wdata are combinational.
- Error flag is sticky per transaction and cleared on leaving IDLE. It is set by any of:
  - rresp≠OKAY on any beat.
  - rlast mismatching the final-beat position.
  - bresp≠OKAY.
- A transaction with an error still runs to completion.
- Counter width is log2(BEATS). It wraps to 0 only through DONE, never mid-burst.

## Timing

- Reset: state IDLE. Every valid, ready, shift, hold, o_done and o_error output is 0; counter 0; latched address 0.
- Reset mid-burst: return to IDLE the next cycle and drop all valids. The AXI slave must also be reset.
- Request accepted in cycle N → o_arvalid/o_awvalid high at N+1. The line buffer captures the cache block in cycle N, because the hold is still low then.
- Valid stays asserted, with stable payload, until the ready handshake.
- Stall-free refill: 1 (AR) + 16 (R) + 1 (DONE) = o_done at N+18.
- Stall-free write-back: 1 (AW) + 16 (W) + 1 (B) + 1 (DONE) = o_done at N+19.
- Requests that arrive outside IDLE are ignored, not queued.

## Test plan

- Refill at i_addr=0x0000_1234, zero-wait slave returning beats 0x0..0xF:
  - araddr=0x0000_1200, arlen=15, arsize=2, arburst=1.
  - 16 shift pulses, o_buf_data = each beat.
  - o_done at N+18, o_error=0.
- Write-back with the buffer preloaded with words 0xA0..0xAF:
  - wdata sequence 0xA0..0xAF, wlast only on the 16th beat.
  - o_done after B, with bresp=OKAY.
- Random rvalid/wready/arready/awready/bvalid stalls: valid and payload stay stable across the stalls, beat count is still exactly 16, and there is no shift without a handshake.
- Both requests high together:
  - Write-back runs first, then i_start_read is honoured in the next IDLE.
  - rresp=SLVERR on beat 5 → o_error=1 with o_done.
- Early rlast on beat 10 → o_error=1 and the burst still completes 16 beats. Separately, assert arst in W at beat 7 → all outputs 0 and state IDLE on the next cycle.
